// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: four-requester round-robin arbiter in front of a single RAM write port.
// Grants are combinational on req_ready; the winning write is registered onto
// we/write_addr/DI/grant_id one cycle later.
// Optional feature: define RAM_INIT_CLEAR_EN to add an INIT state that clears every
// RAM word (one write per cycle, ascending) after each reset before arbitration starts.
module ram_write_arbiter #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [3:0]            req_valid,
   input  logic [4*ADDR_W-1:0]   req_addr,
   input  logic [4*DATA_W-1:0]   req_data,
   output logic [3:0]            req_ready,
   output logic                  we,
   output logic [ADDR_W-1:0]     write_addr,
   output logic [DATA_W-1:0]     DI,
   output logic [1:0]            grant_id,
   output logic                  busy,
   output logic [7:0]            conflict_cnt
);

   logic                arb_en;     // arbitration allowed this cycle
   logic                init_we;    // clear sweep issues a write this cycle
   logic [ADDR_W-1:0]   init_addr;

   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [1:0]          gid_q, gid_d;
   logic [1:0]          last_q, last_d;
   logic [7:0]          cnt_q, cnt_d;

   logic                xfer;
   logic [1:0]          grant_idx;
   logic [1:0]          cand;

`ifdef RAM_INIT_CLEAR_EN
   typedef enum logic [0:0] {StInit, StArb} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   sweep_q, sweep_d;

   // State and sweep counter; reset always restarts the sweep at address 0
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StInit;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // Next state: sweep every address once, then hand over to arbitration
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      init_we = 1'b0;
      unique case (state_q)
         StInit: begin
            init_we = 1'b1;
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = StArb;
         end
         StArb: ;
         default: state_d = StArb;
      endcase
   end

   assign init_addr = sweep_q;
   assign busy      = (state_q == StInit);
   assign arb_en    = (state_q == StArb) && !RST;
`else
   assign init_we   = 1'b0;
   assign init_addr = '0;
   assign busy      = 1'b0;
   assign arb_en    = !RST;
`endif

   // Round-robin pick starting after the last granted requester; nothing granted in reset
   always_comb begin
      req_ready = '0;
      grant_idx = '0;
      xfer      = 1'b0;
      cand      = '0;
      if (arb_en) begin
         for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!xfer && req_valid[cand]) begin
               xfer      = 1'b1;
               grant_idx = cand;
            end
         end
      end
      if (xfer) req_ready[grant_idx] = 1'b1;
   end

   // Next write-port contents, priority pointer and conflict counter
   always_comb begin
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      gid_d  = gid_q;
      last_d = last_q;
      cnt_d  = cnt_q;
      if (init_we) begin
         we_d   = 1'b1;
         addr_d = init_addr;
         data_d = '0;
         gid_d  = '0;
      end else if (xfer) begin
         we_d   = 1'b1;
         addr_d = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
         data_d = req_data[int'(grant_idx)*DATA_W +: DATA_W];
         gid_d  = grant_idx;
         last_d = grant_idx;
      end
      if (arb_en && ($countones(req_valid) >= 2) && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
   end

   // Registered outputs; reset drops any write that would have been issued
   always_ff @(posedge CLK) begin
      if (RST) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         gid_q  <= '0;
         last_q <= 2'd3;
         cnt_q  <= '0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         gid_q  <= gid_d;
         last_q <= last_d;
         cnt_q  <= cnt_d;
      end
   end

   assign we           = we_q;
   assign write_addr   = addr_q;
   assign DI           = data_q;
   assign grant_id     = gid_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: doc/ram_write_arbiter.md
RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, RAM word width; depth is fixed at 2**ADDR_W words.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state updates on posedge CLK.
REQ-004 The block SHALL have port RST, input, 1, reset; it is synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 4, per-requester write request.
REQ-006 The block SHALL have port req_addr, input, 4*ADDR_W, packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
REQ-007 The block SHALL have port req_data, input, 4*DATA_W, packed write data; requester i uses bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port req_ready, output, 4, one-hot (or zero) combinational grant; a transfer occurs on a cycle with req_valid[i] & req_ready[i].
REQ-009 The block SHALL have port we, output, 1, registered RAM write enable.
REQ-010 The block SHALL have port write_addr, output, ADDR_W, registered RAM write address.
REQ-011 The block SHALL have port DI, output, DATA_W, registered RAM write data.
REQ-012 The block SHALL have port grant_id, output, 2, registered index of the requester whose write is on we/write_addr/DI.
REQ-013 The block SHALL have port busy, output, 1, high while requests cannot be accepted (INIT state).
REQ-014 The block SHALL have port conflict_cnt, output, 8, saturating count of cycles in ARB with two or more req_valid bits set.

Function
REQ-015 The FSM SHALL have states INIT and ARB; INIT exists only when the configuration macro is defined.
REQ-016 In ARB, req_ready SHALL grant exactly one valid requester per cycle, or none when req_valid is 0.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4 and wraps; last_grant updates only on a transfer.
REQ-018 A requester SHALL hold req_valid, req_addr and req_data stable until its transfer; the block never drops an accepted request.
REQ-019 A transfer in cycle N SHALL present we=1, write_addr, DI and grant_id for that request in cycle N+1; the RAM is written at the end of N+1.
REQ-020 With no transfer in cycle N, we SHALL be 0 in cycle N+1; write_addr, DI and grant_id hold their previous values.
REQ-021 Sustained throughput SHALL be one write per cycle; a requester with valid held waits at most 3 cycles for a grant.
REQ-022 Writes to the same address from different requesters SHALL commit in grant order; the later grant's data remains.
REQ-023 conflict_cnt SHALL increment by 1 per ARB cycle with popcount(req_valid) >= 2, saturate at 8'hFF, and never wrap.

Reset
REQ-024 While RST is high at a clock edge: we=0, write_addr=0, DI=0, grant_id=0, last_grant=3 (requester 0 has first priority), and conflict_cnt=0.
REQ-025 Reset SHALL override all activity; RST asserted mid-INIT or mid-stream SHALL abort the operation, so an in-flight write in the cycle after RST is not issued.
REQ-026 After RST, the FSM SHALL enter INIT when the macro is defined and ARB otherwise; busy SHALL reflect the entered state in the first cycle after reset.

Configuration
REQ-027 Macro RAM_INIT_CLEAR_EN SHALL control the clear-on-reset sweep.
REQ-028 With RAM_INIT_CLEAR_EN defined, INIT SHALL write DATA_W'h0 to addresses 0 to 2**ADDR_W-1, one per cycle in ascending order, with we=1, grant_id=0, busy=1 and req_ready=0.
REQ-029 With RAM_INIT_CLEAR_EN defined, the FSM SHALL move to ARB after the write to the last address is issued, and busy SHALL fall in the following cycle.
REQ-030 Reset during INIT SHALL restart the sweep at address 0.
REQ-031 Without RAM_INIT_CLEAR_EN, no INIT logic or sweep counter SHALL exist, and busy SHALL be tied to 0.

Verification
REQ-032 Macro on, RST for 1 cycle, then idle: the bench SHALL see we=1 for exactly 64 cycles with write_addr 0..63 and DI=0, then busy=0.
REQ-033 Single requester: req_valid=4'b0100, addr=6'h2A, data=16'hBEEF; the bench SHALL see req_ready=4'b0100, then next cycle we=1, write_addr=6'h2A, DI=16'hBEEF, grant_id=2.
REQ-034 All four requesters held valid after reset: the bench SHALL see grants in order 0,1,2,3,0,... with we=1 every cycle and conflict_cnt incrementing each cycle.
REQ-035 Requesters 1 and 3 both target addr 6'h05 with data 16'h1111 and 16'h3333 from last_grant=0: the bench SHALL see RAM[5] end at 16'h3333.
REQ-036 RST asserted on the cycle of a transfer and again at INIT address 6'h1F: the bench SHALL see no write for the aborted transfer, and the sweep restart at address 0.
REQ-037 conflict_cnt saturation: holding 2 valid requesters for 300 cycles SHALL leave conflict_cnt=8'hFF.
